// File: rtl/dsp_gen_pkg.sv
// dsp_gen_pkg: X/Z select encodings, OPMODE bit indices and counter-width helper for dsp_slice_gen
package dsp_gen_pkg;
  typedef enum logic [1:0] {X_ZERO, X_M, X_P, X_DAB} xsel_e;
  typedef enum logic [1:0] {Z_ZERO, Z_PCIN, Z_P, Z_C} zsel_e;
  localparam int OP_PRE_EN   = 4;
  localparam int OP_CIN      = 5;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_POST_SUB = 7;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dsp_preadd_mult.sv
// dsp_preadd_mult: stage-2 pre-adder (B, D+B or D-B) and A*BCOUT product registers
module dsp_preadd_mult #(
  parameter int A_W = 18,
  parameter int B_W = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic [B_W-1:0]     d,
  input  logic               pre_en,
  input  logic               pre_sub,
  output logic [B_W-1:0]     bcout,
  output logic [A_W+B_W-1:0] m
);
  logic [B_W-1:0]     bc_d, bc_q;
  logic [A_W+B_W-1:0] m_d, m_q;
  always_comb begin
    bc_d = pre_en ? (pre_sub ? d - b : d + b) : b;
    m_d = (A_W+B_W)'(a) * (A_W+B_W)'(bc_d);
  end
  always_ff @(posedge clk)
    if (rst) begin
      bc_q <= '0;
      m_q <= '0;
    end else if (ce) begin
      bc_q <= bc_d;
      m_q <= m_d;
    end
  assign bcout = bc_q;
  assign m = m_q;
endmodule

// File: rtl/dsp_slice_gen.sv
// dsp_slice_gen: 3-stage pre-add/multiply/post-add slice with valid pipeline, CE stall, auto-dump accumulate, optional PATTERN_DETECT_EN
module dsp_slice_gen
  import dsp_gen_pkg::*;
#(
  parameter int    A_W     = 18,
  parameter int    B_W     = 18,
  parameter int    P_W     = 48,
  parameter string B_INPUT = "DIRECT",
  parameter int    ACC_LEN = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  input  logic [B_W-1:0]     D,
  input  logic [B_W-1:0]     BCIN,
  input  logic [P_W-1:0]     C,
  input  logic [P_W-1:0]     PCIN,
  input  logic [7:0]         OPMODE,
  input  logic               CARRYIN,
  output logic [B_W-1:0]     BCOUT,
  output logic [A_W+B_W-1:0] M,
  output logic [P_W-1:0]     P,
  output logic [P_W-1:0]     PCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF,
  output logic               OUT_VALID,
  output logic               ACC_DONE
`ifdef PATTERN_DETECT_EN
  ,
  input  logic [P_W-1:0]     PATTERN,
  input  logic [P_W-1:0]     MASK,
  output logic               PATTERN_DET
`endif
);
  localparam bit CASC = B_INPUT == "CASCADE";
  localparam bit DUMP = ACC_LEN > 0;
  localparam int CW = cnt_w(ACC_LEN);
  logic [A_W-1:0] a1_d, a1_q;
  logic [B_W-1:0] b1_d, b1_q, d1_d, d1_q;
  logic [P_W-1:0] c1_d, c1_q, pc1_d, pc1_q, c2_d, c2_q, pc2_d, pc2_q, dab2_d, dab2_q, p_d, p_q;
  logic [7:0]     op1_d, op1_q, op2_d, op2_q;
  logic           v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, co_d, co_q, done_d, done_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic [P_W-1:0] x, z;
  logic [P_W:0]   sum;
  xsel_e          xs;
  zsel_e          zs;
  logic           zp, last, fresh;
  dsp_preadd_mult #(.A_W(A_W), .B_W(B_W)) u_pm (
    .clk(CLK), .rst(RST), .ce(CE), .a(a1_q), .b(b1_q), .d(d1_q),
    .pre_en(op1_q[OP_PRE_EN]), .pre_sub(op1_q[OP_PRE_SUB]), .bcout(BCOUT), .m(M)
  );
  always_comb begin
    a1_d = A;
    b1_d = CASC ? BCIN : B;
    d1_d = D;
    c1_d = C;
    pc1_d = PCIN;
    op1_d = OPMODE;
    v1_d = IN_VALID;
    c2_d = c1_q;
    pc2_d = pc1_q;
    op2_d = op1_q;
    v2_d = v1_q;
    dab2_d = P_W'({d1_q, a1_q, b1_q});
    xs = xsel_e'(op2_q[1:0]);
    zs = zsel_e'(op2_q[3:2]);
    zp = zs == Z_P;
    last = DUMP && cnt_q == CW'(ACC_LEN - 1);
    // the first sample of every auto-dump group starts from zero instead of the old P
    fresh = DUMP && zp && cnt_q == '0;
    x = xs == X_M ? P_W'(M) : xs == X_P ? p_q : xs == X_DAB ? dab2_q : '0;
    z = zs == Z_PCIN ? pc2_q : zs == Z_C ? c2_q : (zp && !fresh) ? p_q : '0;
    sum = op2_q[OP_POST_SUB] ? {1'b0, z} - {1'b0, x} - (P_W+1)'(op2_q[OP_CIN])
                             : {1'b0, z} + {1'b0, x} + (P_W+1)'(op2_q[OP_CIN]);
    p_d = v2_q ? sum[P_W-1:0] : p_q;
    co_d = v2_q ? sum[P_W] : co_q;
    done_d = v2_q && DUMP && zp && last;
    cnt_d = v2_q ? ((DUMP && zp && !last) ? cnt_q + 1'b1 : '0) : cnt_q;
    v3_d = v2_q;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      a1_q <= '0;
      b1_q <= '0;
      d1_q <= '0;
      c1_q <= '0;
      pc1_q <= '0;
      op1_q <= '0;
      v1_q <= 1'b0;
      c2_q <= '0;
      pc2_q <= '0;
      op2_q <= '0;
      v2_q <= 1'b0;
      dab2_q <= '0;
      p_q <= '0;
      co_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      v3_q <= 1'b0;
    end else if (CE) begin
      a1_q <= a1_d;
      b1_q <= b1_d;
      d1_q <= d1_d;
      c1_q <= c1_d;
      pc1_q <= pc1_d;
      op1_q <= op1_d;
      v1_q <= v1_d;
      c2_q <= c2_d;
      pc2_q <= pc2_d;
      op2_q <= op2_d;
      v2_q <= v2_d;
      dab2_q <= dab2_d;
      p_q <= p_d;
      co_q <= co_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      v3_q <= v3_d;
    end
`ifdef PATTERN_DETECT_EN
  logic pd_d, pd_q;
  always_comb pd_d = v2_q ? (((sum[P_W-1:0] ^ PATTERN) & ~MASK) == '0) : pd_q;
  always_ff @(posedge CLK)
    if (RST) pd_q <= 1'b0;
    else if (CE) pd_q <= pd_d;
  assign PATTERN_DET = pd_q;
`endif
  logic unused_ok;
  assign unused_ok = ^{CARRYIN, op2_q[OP_PRE_EN], op2_q[OP_PRE_SUB]};
  assign P = p_q;
  assign PCOUT = p_q;
  assign CARRYOUT = co_q;
  assign CARRYOUTF = co_q;
  assign OUT_VALID = v3_q;
  assign ACC_DONE = done_q;
endmodule

// File: tb/tb_dsp_slice_gen.sv
// tb_dsp_slice_gen: randomized scoreboard bench for dsp_slice_gen with ACC_LEN=4
module tb_dsp_slice_gen;
  localparam int ACC = 4;
  localparam longint unsigned M18 = 64'h3FFFF;
  localparam longint unsigned M48 = 64'hFFFF_FFFF_FFFF;
  logic clk = 0, RST = 1, CE = 0, IN_VALID = 0, CARRYIN = 0;
  logic [17:0] A = 0, B = 0, D = 0, BCIN = 0, BCOUT;
  logic [47:0] C = 0, PCIN = 0, P, PCOUT;
  logic [35:0] M;
  logic [7:0]  OPMODE = 0;
  logic CARRYOUT, CARRYOUTF, OUT_VALID, ACC_DONE;
`ifdef PATTERN_DETECT_EN
  logic [47:0] pat = '0, msk = '1;
  logic pdet;
`endif
  typedef struct {
    longint unsigned p, m, bc;
    bit co, done, chk_m;
    int due;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, en_cnt = 0;
  bit ce_seen = 0, rst_seen = 1;
  longint unsigned mp = 0;
  int mcnt = 0;

  dsp_slice_gen #(.ACC_LEN(ACC)) dut (
`ifdef PATTERN_DETECT_EN
    .PATTERN(pat), .MASK(msk), .PATTERN_DET(pdet),
`endif
    .CLK(clk), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B), .D(D), .BCIN(BCIN),
    .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .CARRYIN(CARRYIN), .BCOUT(BCOUT), .M(M), .P(P),
    .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF), .OUT_VALID(OUT_VALID), .ACC_DONE(ACC_DONE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ce_seen <= CE;
    rst_seen <= RST;
    if (CE && !RST) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input longint unsigned a, b, d, c, pc, input bit [7:0] op, input bit cm);
    exp_t e;
    longint unsigned x, z, s, cin;
    e.bc = op[4] ? ((op[6] ? d - b : d + b) & M18) : b;
    e.m = a * e.bc;
    case (op[1:0])
      2'd0: x = 0;
      2'd1: x = e.m;
      2'd2: x = mp;
      default: x = ((d << 36) | (a << 18) | b) & M48;
    endcase
    case (op[3:2])
      2'd0: z = 0;
      2'd1: z = pc;
      2'd2: z = (mcnt == 0) ? 0 : mp;
      default: z = c;
    endcase
    cin = op[5];
    s = (op[7] ? z - x - cin : z + x + cin) & ((64'd1 << 49) - 1);
    e.p = s & M48;
    e.co = s[48];
    e.done = 0;
    if (op[3:2] == 2'd2) begin
      e.done = mcnt == ACC - 1;
      mcnt = e.done ? 0 : mcnt + 1;
    end else mcnt = 0;
    mp = e.p;
    e.chk_m = cm;
    e.due = en_cnt + 3;
    return e;
  endfunction

  task automatic send(input bit v, input bit [17:0] a, b, d, input bit [47:0] c, pc, input bit [7:0] op, input bit cm);
    exp_t e;
    @(negedge clk); #1;
    RST = 0; CE = 1; IN_VALID = v; A = a; B = b; D = d; BCIN = ~b; C = c; PCIN = pc; OPMODE = op;
    CARRYIN = 1'($urandom);
    if (v) begin
      e = model(a, b, d, c, pc, op, cm);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      RST = 0; CE = 1; IN_VALID = 0;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      CE = 0; IN_VALID = 1'($urandom); A = 18'($urandom); B = 18'($urandom); OPMODE = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      q.delete(); mp = 0; mcnt = 0;
      RST = 1; CE = 1'($urandom); IN_VALID = 1'($urandom); A = 18'($urandom); B = 18'($urandom);
      D = 18'($urandom); C = 48'({$urandom, $urandom}); PCIN = 48'({$urandom, $urandom}); OPMODE = 8'($urandom);
    end
    @(negedge clk); #1;
    chk("rst_BCOUT", BCOUT, 0); chk("rst_M", M, 0); chk("rst_P", P, 0); chk("rst_PCOUT", PCOUT, 0);
    chk("rst_CARRYOUT", CARRYOUT, 0); chk("rst_CARRYOUTF", CARRYOUTF, 0);
    chk("rst_OUT_VALID", OUT_VALID, 0); chk("rst_ACC_DONE", ACC_DONE, 0);
    RST = 0; CE = 1; IN_VALID = 0;
  endtask

  initial begin : monitor
    exp_t e;
    logic [47:0] sp;
    logic sv, sd, sc;
    logic [35:0] sm;
    logic [17:0] sb;
    forever begin
      @(negedge clk);
      if (!rst_seen && ce_seen) begin
        if (OUT_VALID) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_valid: OUT_VALID=1 want 0 (no sample in flight) at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("latency", longint'(en_cnt), longint'(e.due));
            chk("P", P, e.p); chk("PCOUT", PCOUT, e.p);
            chk("CARRYOUT", CARRYOUT, e.co); chk("CARRYOUTF", CARRYOUTF, e.co);
            chk("ACC_DONE", ACC_DONE, e.done);
            if (e.chk_m) begin
              chk("M", M, e.m); chk("BCOUT", BCOUT, e.bc);
            end
          end
        end else chk("idle_ACC_DONE", ACC_DONE, 0);
      end else if (!rst_seen) begin
        chk("hold_P", P, sp); chk("hold_OUT_VALID", OUT_VALID, sv); chk("hold_ACC_DONE", ACC_DONE, sd);
        chk("hold_CARRYOUT", CARRYOUT, sc); chk("hold_M", M, sm); chk("hold_BCOUT", BCOUT, sb);
      end
      sp = P; sv = OUT_VALID; sd = ACC_DONE; sc = CARRYOUT; sm = M; sb = BCOUT;
    end
  end

  initial begin : driver
    int r;
    bit [7:0] op;
    do_reset(2);
    send(1, 20, 10, 25, 350, 0, 8'b11011101, 1); idle(5);
    send(1, 5, 6, 7, 0, 3000, 8'b10100111, 1); idle(5);
    for (int i = 0; i < 8; i++) send(1, 2, 3, 0, 0, 0, 8'b00001001, 1);
    idle(5);
    send(1, 9, 4, 1, 1000, 0, 8'b00001101, 0);
    send(1, 3, 3, 2, 77, 0, 8'b00011101, 0);
    stall(2);
    send(1, 7, 1, 5, 5, 0, 8'b00001101, 0);
    idle(5);
    send(1, 2, 3, 0, 0, 0, 8'b00001001, 1); send(1, 2, 3, 0, 0, 0, 8'b00001001, 1); idle(5);
    send(1, 2, 3, 0, 0, 0, 8'b00001001, 1); send(1, 2, 3, 0, 0, 0, 8'b00001001, 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) send(1, 2, 3, 0, 0, 0, 8'b00001001, 1);
    idle(5);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      op = 8'($urandom);
      if ($urandom_range(1) == 1) op[3:2] = 2'b10;
      if (r < 2) do_reset(1);
      else if (r < 12) stall(1);
      else send(r < 80, 18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
                48'({$urandom, $urandom}), op, 0);
    end
    idle(6);
    chk("drained", longint'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
